// File: rtl/sram_arb_if.sv
// rtl/sram_arb_if.sv - CPU byte port, DMA word port and SRAM pin bundle for sram_arb
interface sram_arb_if #(
  parameter int AW = 22
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW:0]   cpu_addr;
  logic [7:0]    cpu_dati;
  logic [7:0]    cpu_dato;
  logic          cpu_ack;
  logic          cpu_ovf;
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [15:0]   dma_dati;
  logic [15:0]   dma_dato;
  logic          dma_ack;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_dout;
  logic [15:0]   ram_din;
  logic          ram_dq_oe;
  logic          ram_oe_n;
  logic          ram_we_n;
  logic          ram_ub_n;
  logic          ram_lb_n;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_dati,
    output cpu_dato, cpu_ack, cpu_ovf,
    input  dma_req, dma_we, dma_addr, dma_dati,
    output dma_dato, dma_ack,
    output ram_addr, ram_dout, ram_dq_oe, ram_oe_n, ram_we_n, ram_ub_n, ram_lb_n,
    input  ram_din
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_dati,
    input  cpu_dato, cpu_ack, cpu_ovf,
    output dma_req, dma_we, dma_addr, dma_dati,
    input  dma_dato, dma_ack,
    input  ram_addr, ram_dout, ram_dq_oe, ram_oe_n, ram_we_n, ram_ub_n, ram_lb_n,
    output ram_din
  );
endinterface

// File: rtl/sram_arb.sv
// rtl/sram_arb.sv - CPU-priority arbiter and wait-state sequencer for a 16-bit async SRAM
module sram_arb #(
  parameter int AW    = 22,
  parameter int RD_WS = 3,
  parameter int WR_WS = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  sram_arb_if.slave    bus
);
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE} state_t;

  localparam logic [3:0] RD_LD = 4'(RD_WS - 1);
  localparam logic [3:0] WR_LD = 4'(WR_WS - 1);

  state_t        state_q, state_d;
  logic          own_cpu_q, own_cpu_d;
  logic          we_q, we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [15:0]   ram_dout_q, ram_dout_d;
  logic          ub_n_q, ub_n_d;
  logic          lb_n_q, lb_n_d;
  logic [3:0]    ws_ctr_q, ws_ctr_d;
  logic          cpu_pend_q, cpu_pend_d;
  logic          pend_we_q, pend_we_d;
  logic [AW:0]   pend_addr_q, pend_addr_d;
  logic [7:0]    pend_dati_q, pend_dati_d;
  logic          cpu_ovf_q, cpu_ovf_d;
  logic [7:0]    cpu_dato_q, cpu_dato_d;
  logic [15:0]   dma_dato_q, dma_dato_d;

  logic          cpu_grant;
  logic          g_we;
  logic [AW:0]   g_addr;
  logic [7:0]    g_dati;

  always_comb begin
    state_d     = state_q;
    own_cpu_d   = own_cpu_q;
    we_d        = we_q;
    ram_addr_d  = ram_addr_q;
    ram_dout_d  = ram_dout_q;
    ub_n_d      = ub_n_q;
    lb_n_d      = lb_n_q;
    ws_ctr_d    = ws_ctr_q;
    cpu_pend_d  = cpu_pend_q;
    pend_we_d   = pend_we_q;
    pend_addr_d = pend_addr_q;
    pend_dati_d = pend_dati_q;
    cpu_ovf_d   = cpu_ovf_q;
    cpu_dato_d  = cpu_dato_q;
    dma_dato_d  = dma_dato_q;

    cpu_grant = (state_q == IDLE) && (bus.cpu_req || cpu_pend_q);
    g_we      = cpu_pend_q ? pend_we_q   : bus.cpu_we;
    g_addr    = cpu_pend_q ? pend_addr_q : bus.cpu_addr;
    g_dati    = cpu_pend_q ? pend_dati_q : bus.cpu_dati;

    // A pending request is always served before a fresh strobe, which then takes its slot.
    if (bus.cpu_req) begin
      if (cpu_pend_q && !cpu_grant) begin
        cpu_ovf_d = 1'b1;
      end else if (cpu_pend_q || !cpu_grant) begin
        cpu_pend_d  = 1'b1;
        pend_we_d   = bus.cpu_we;
        pend_addr_d = bus.cpu_addr;
        pend_dati_d = bus.cpu_dati;
      end
    end else if (cpu_grant) begin
      cpu_pend_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cpu_grant) begin
          own_cpu_d  = 1'b1;
          we_d       = g_we;
          ram_addr_d = g_addr[AW:1];
          ram_dout_d = {g_dati, g_dati};
          ub_n_d     = ~g_addr[0];
          lb_n_d     = g_addr[0];
          state_d    = SETUP;
        end else if (bus.dma_req) begin
          own_cpu_d  = 1'b0;
          we_d       = bus.dma_we;
          ram_addr_d = bus.dma_addr;
          ram_dout_d = bus.dma_dati;
          ub_n_d     = 1'b0;
          lb_n_d     = 1'b0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        ws_ctr_d = we_q ? WR_LD : RD_LD;
        state_d  = ACCESS;
      end
      ACCESS: begin
        if (ws_ctr_q == 4'd0) begin
          if (we_q) begin
            state_d = HOLD;
          end else begin
            state_d = DONE;
            if (own_cpu_q) begin
              cpu_dato_d = ub_n_q ? bus.ram_din[7:0] : bus.ram_din[15:8];
            end else begin
              dma_dato_d = bus.ram_din;
            end
          end
        end else begin
          ws_ctr_d = ws_ctr_q - 4'd1;
        end
      end
      HOLD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      own_cpu_q   <= 1'b0;
      we_q        <= 1'b0;
      ram_addr_q  <= '0;
      ram_dout_q  <= '0;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      ws_ctr_q    <= '0;
      cpu_pend_q  <= 1'b0;
      pend_we_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_dati_q <= '0;
      cpu_ovf_q   <= 1'b0;
      cpu_dato_q  <= '0;
      dma_dato_q  <= '0;
    end else begin
      state_q     <= state_d;
      own_cpu_q   <= own_cpu_d;
      we_q        <= we_d;
      ram_addr_q  <= ram_addr_d;
      ram_dout_q  <= ram_dout_d;
      ub_n_q      <= ub_n_d;
      lb_n_q      <= lb_n_d;
      ws_ctr_q    <= ws_ctr_d;
      cpu_pend_q  <= cpu_pend_d;
      pend_we_q   <= pend_we_d;
      pend_addr_q <= pend_addr_d;
      pend_dati_q <= pend_dati_d;
      cpu_ovf_q   <= cpu_ovf_d;
      cpu_dato_q  <= cpu_dato_d;
      dma_dato_q  <= dma_dato_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them in the same cycle.
  logic active;
  assign active = (state_q == SETUP) || (state_q == ACCESS) || (state_q == HOLD);

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_dout  = ram_dout_q;
  assign bus.ram_dq_oe = active && we_q;
  assign bus.ram_oe_n  = !(((state_q == SETUP) || (state_q == ACCESS)) && !we_q);
  assign bus.ram_we_n  = !((state_q == ACCESS) && we_q);
  assign bus.ram_ub_n  = active ? ub_n_q : 1'b1;
  assign bus.ram_lb_n  = active ? lb_n_q : 1'b1;
  assign bus.cpu_ack   = (state_q == DONE) && own_cpu_q;
  assign bus.dma_ack   = (state_q == DONE) && !own_cpu_q;
  assign bus.cpu_dato  = cpu_dato_q;
  assign bus.dma_dato  = dma_dato_q;
  assign bus.cpu_ovf   = cpu_ovf_q;
endmodule

// File: tb/tb_sram_arb.sv
// tb/tb_sram_arb.sv - scoreboard bench for sram_arb with an SRAM pin model and shadow memory
module tb_sram_arb;
  localparam int AW     = 22;
  localparam int RD_WS  = 3;
  localparam int WR_WS  = 2;
  localparam int RD_LAT = RD_WS + 2;
  localparam int WR_LAT = WR_WS + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_arb_if #(.AW(AW)) bus ();
  sram_arb #(.AW(AW), .RD_WS(RD_WS), .WR_WS(WR_WS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    bit          rd;
    logic [15:0] data;
    int          ack;
  } exp_t;

  exp_t        cpu_q[$];
  exp_t        dma_q[$];
  exp_t        mon_e;
  logic [15:0] mem[int];
  logic [15:0] shadow[int];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          we_low = 0;
  logic [AW-1:0] w_addr;
  logic [15:0]   w_dout;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mrd(input int a);
    return mem.exists(a) ? mem[a] : 16'h0;
  endfunction

  function automatic logic [15:0] srd(input int a);
    return shadow.exists(a) ? shadow[a] : 16'h0;
  endfunction

  // SRAM pins plus scoreboard: everything sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      we_low = 0;
      bus.ram_din = 16'h0;
    end else begin
      bus.ram_din = !bus.ram_oe_n ? mrd(int'(bus.ram_addr)) : 16'h0;
      chk("oe_dq_exclusive", 32'(!bus.ram_oe_n && bus.ram_dq_oe), 0);
      if (!bus.ram_we_n) begin
        if (we_low == 0) begin
          w_addr = bus.ram_addr;
          w_dout = bus.ram_dout;
        end else begin
          chk("wr_addr_stable", 32'(bus.ram_addr), 32'(w_addr));
          chk("wr_dout_stable", 32'(bus.ram_dout), 32'(w_dout));
        end
        begin
          logic [15:0] w;
          w = mrd(int'(bus.ram_addr));
          if (!bus.ram_lb_n) w[7:0] = bus.ram_dout[7:0];
          if (!bus.ram_ub_n) w[15:8] = bus.ram_dout[15:8];
          mem[int'(bus.ram_addr)] = w;
        end
        we_low++;
      end else if (we_low != 0) begin
        chk("we_n_low_cycles", 32'(we_low), 32'(WR_WS));
        chk("hold_dq_oe", 32'(bus.ram_dq_oe), 1);
        chk("hold_dout", 32'(bus.ram_dout), 32'(w_dout));
        we_low = 0;
      end
      if (bus.cpu_ack) begin
        if (cpu_q.size() == 0) chk("cpu_spurious_ack", 1, 0);
        else begin
          mon_e = cpu_q.pop_front();
          if (mon_e.ack >= 0) chk("cpu_ack_cycle", 32'(cyc + 1), 32'(mon_e.ack));
          if (mon_e.rd) chk("cpu_dato", 32'(bus.cpu_dato), 32'(mon_e.data));
        end
      end
      if (bus.dma_ack) begin
        if (dma_q.size() == 0) chk("dma_spurious_ack", 1, 0);
        else begin
          mon_e = dma_q.pop_front();
          if (mon_e.ack >= 0) chk("dma_ack_cycle", 32'(cyc + 1), 32'(mon_e.ack));
          if (mon_e.rd) chk("dma_dato", 32'(bus.dma_dato), 32'(mon_e.data));
        end
      end
    end
  end

  task automatic cpu_go(input bit we, input logic [AW:0] a, input logic [7:0] d, input int ack_edge);
    exp_t e;
    int w;
    int t;
    logic [15:0] s;
    w = int'(a >> 1);
    s = srd(w);
    e.rd = !we;
    e.ack = ack_edge;
    e.data = a[0] ? {8'h0, s[15:8]} : {8'h0, s[7:0]};
    if (we) begin
      if (a[0]) s[15:8] = d; else s[7:0] = d;
      shadow[w] = s;
    end
    cpu_q.push_back(e);
    bus.cpu_req = 1'b1;
    bus.cpu_we = we;
    bus.cpu_addr = a;
    bus.cpu_dati = d;
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.cpu_ack && t < 400);
    if (!bus.cpu_ack) chk("cpu_ack_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic dma_go(input bit we, input logic [AW-1:0] a, input logic [15:0] d, input int ack_edge);
    exp_t e;
    int t;
    e.rd = !we;
    e.ack = ack_edge;
    e.data = srd(int'(a));
    if (we) shadow[int'(a)] = d;
    dma_q.push_back(e);
    bus.dma_req = 1'b1;
    bus.dma_we = we;
    bus.dma_addr = a;
    bus.dma_dati = d;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.dma_ack && t < 400);
    if (!bus.dma_ack) chk("dma_ack_timeout", 0, 1);
    @(posedge clk); #1;
    bus.dma_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int acks;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_dati = '0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_dati = '0;
    bus.ram_din = '0;
    for (int i = 0; i < 64; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      mem[i] = r;
      shadow[i] = r;
    end
    mem[2] = 16'hA55A;
    shadow[2] = 16'hA55A;
    mem[32'h1234] = 16'h0;
    shadow[32'h1234] = 16'h0;

    #12;
    chk("rst_oe_n", 32'(bus.ram_oe_n), 1);
    chk("rst_we_n", 32'(bus.ram_we_n), 1);
    chk("rst_lanes", 32'({bus.ram_ub_n, bus.ram_lb_n}), 3);
    chk("rst_dq_oe", 32'(bus.ram_dq_oe), 0);
    chk("rst_acks", 32'({bus.cpu_ack, bus.dma_ack}), 0);
    chk("rst_ovf", 32'(bus.cpu_ovf), 0);
    chk("rst_addr_dout", 32'({bus.ram_addr, bus.ram_dout}), 0);
    chk("rst_dato", 32'({bus.cpu_dato, bus.dma_dato}), 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    idle(2);

    // CPU byte read from the upper lane
    k = cyc;
    fork
      cpu_go(1'b0, 23'h000005, 8'h00, k + 1 + RD_LAT);
      begin
        @(posedge clk); #1;
        chk("t2_ram_addr", 32'(bus.ram_addr), 32'h2);
        chk("t2_lanes_ub_lb", 32'({bus.ram_ub_n, bus.ram_lb_n}), 32'b01);
        chk("t2_oe_n", 32'(bus.ram_oe_n), 0);
        chk("t2_dq_oe", 32'(bus.ram_dq_oe), 0);
      end
    join
    chk("t2_cpu_dato_hold", 32'(bus.cpu_dato), 32'hA5);
    idle(2);

    // DMA word write
    k = cyc;
    fork
      dma_go(1'b1, 22'h1234, 16'hBEEF, k + 1 + WR_LAT);
      begin
        @(posedge clk); #1;
        chk("t3_setup_dout", 32'(bus.ram_dout), 32'hBEEF);
        chk("t3_setup_we_n", 32'(bus.ram_we_n), 1);
        chk("t3_setup_dq_oe", 32'(bus.ram_dq_oe), 1);
        chk("t3_lanes", 32'({bus.ram_ub_n, bus.ram_lb_n}), 0);
      end
    join
    chk("t3_mem", 32'(mrd(32'h1234)), 32'hBEEF);
    idle(2);

    // Simultaneous requests: CPU first, DMA after one IDLE cycle
    k = cyc;
    fork
      cpu_go(1'b0, 23'h000010, 8'h00, k + 1 + RD_LAT);
      dma_go(1'b0, 22'd20, 16'h0, k + 1 + RD_LAT + 1 + RD_LAT);
    join
    idle(2);

    // CPU strobes during a DMA read: first pends, second overflows
    k = cyc;
    fork
      dma_go(1'b0, 22'd21, 16'h0, k + 1 + RD_LAT);
      begin
        @(posedge clk); #1;
        cpu_go(1'b0, 23'h000013, 8'h00, k + 1 + RD_LAT + 1 + RD_LAT);
      end
      begin
        repeat (3) begin
          @(posedge clk); #1;
        end
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b1;
        bus.cpu_addr = 23'h00003E;
        bus.cpu_dati = 8'h77;
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
      end
    join
    chk("t5_ovf", 32'(bus.cpu_ovf), 1);
    idle(10);
    chk("t5_queues_empty", 32'(cpu_q.size() + dma_q.size()), 0);
    chk("t5_dropped_write", 32'(mrd(31)), 32'(srd(31)));

    // Async reset in the middle of a write ACCESS
    bus.dma_req = 1'b1;
    bus.dma_we = 1'b1;
    bus.dma_addr = 22'd40;
    bus.dma_dati = 16'h1111;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.ram_we_n && k < 20);
    chk("t1_reached_access", 32'(bus.ram_we_n), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_we_n", 32'(bus.ram_we_n), 1);
    chk("t1_dq_oe", 32'(bus.ram_dq_oe), 0);
    chk("t1_oe_n_lanes", 32'({bus.ram_oe_n, bus.ram_ub_n, bus.ram_lb_n}), 7);
    chk("t1_acks", 32'({bus.cpu_ack, bus.dma_ack}), 0);
    chk("t1_ovf_cleared", 32'(bus.cpu_ovf), 0);
    bus.dma_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      acks += int'(bus.dma_ack) + int'(bus.cpu_ack);
    end
    chk("t1_no_ack_after_reset", 32'(acks), 0);
    chk("t1_idle_strobes", 32'({bus.ram_oe_n, bus.ram_we_n, bus.ram_dq_oe}), 32'b110);
    mem[40] = srd(40);
    @(posedge clk); #1;

    // Random traffic, CPU on words 0..15, DMA on words 32..47
    fork
      for (int i = 0; i < 40; i++) begin
        cpu_go(1'($urandom_range(0, 1)), 23'($urandom_range(0, 31)), 8'($urandom), -1);
        idle($urandom_range(1, 4));
      end
      for (int j = 0; j < 40; j++) begin
        dma_go(1'($urandom_range(0, 1)), 22'($urandom_range(32, 47)), 16'($urandom), -1);
        idle($urandom_range(0, 3));
      end
    join
    idle(10);
    chk("rand_queues_empty", 32'(cpu_q.size() + dma_q.size()), 0);
    for (int i = 0; i < 48; i++) begin
      if (i < 16 || i >= 32) chk("rand_mem_final", 32'(mrd(i)), 32'(srd(i)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
